// File: rtl/match_pkg.sv
// match_pkg: shared types and width helpers for the match controller slice.
//   match_state_t : match-level state machine encoding
//   presc_w()     : counter width for a prescaler that counts 0..CLK_FREQ_HZ-1
//   idx_w()       : width of a team index for NUM_TEAMS teams
// Modules derive their localparams PRESC_W and IDX_W from these helpers,
// because the values depend on each instance's parameters.
package match_pkg;

   typedef enum logic [2:0] {
      IDLE,
      PLAYING,
      PAUSED,
      OVERTIME,
      OVER
   } match_state_t;

   function automatic int presc_w(input int clk_freq_hz);
      return (clk_freq_hz > 1) ? $clog2(clk_freq_hz) : 1;
   endfunction

   function automatic int idx_w(input int num_teams);
      return (num_teams > 1) ? $clog2(num_teams) : 1;
   endfunction

endpackage

// File: rtl/match_controller_prescaler.sv
// sec_prescaler: divides the system clock down to a one-per-second tick.
//   clk  in  : system clock
//   rst  in  : synchronous active-high reset, clears the count
//   run  in  : count enable; the count holds while low
//   tick out : high during the cycle the count sits at CLK_FREQ_HZ-1 with run=1
module sec_prescaler
   import match_pkg::*;
#(
   parameter int CLK_FREQ_HZ = 50_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic run,
   output logic tick
);

   localparam int PRESC_W = presc_w(CLK_FREQ_HZ);
   localparam logic [PRESC_W-1:0] TERMINAL = PRESC_W'(CLK_FREQ_HZ - 1);

   logic [PRESC_W-1:0] count;

   assign tick = run && (count == TERMINAL);

   // Holding the count while run is low is what lets a pause resume
   // mid-second instead of restarting the second.
   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
      end else if (run) begin
         count <= tick ? '0 : count + PRESC_W'(1);
      end
   end

endmodule

// File: rtl/match_controller.sv
// match_controller: match start, pause/resume, 1 Hz countdown, per-team
// toggle-protocol score counting and winner resolution.
//   clk, rst          : system clock, synchronous active-high reset
//   start_req         : level, any player button
//   pause_req         : one-cycle pulse, toggles pause while playing
//   score_toggle      : one toggle line per team, each change is a goal
//   time_left         : seconds remaining
//   scores            : packed scores, team i at [i*SCORE_WIDTH +: SCORE_WIDTH]
//   game_on           : PLAYING or OVERTIME
//   game_paused       : PAUSED
//   game_over         : OVER
//   second_tick       : one-cycle pulse with every time_left decrement
//   winner_valid/winner_idx/draw : result, registered on entry to OVER
// Build option: define MATCH_OVERTIME_EN to enable sudden-death OVERTIME
// on a tied top score at expiry; otherwise a tie ends in OVER with draw=1.
module match_controller
   import match_pkg::*;
#(
   parameter int CLK_FREQ_HZ   = 50_000_000,
   parameter int MATCH_SECONDS = 180,
   parameter int NUM_TEAMS     = 2,
   parameter int SCORE_WIDTH   = 7,
   parameter int TIME_WIDTH    = 8
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             start_req,
   input  logic                             pause_req,
   input  logic [NUM_TEAMS-1:0]             score_toggle,
   output logic [TIME_WIDTH-1:0]            time_left,
   output logic [NUM_TEAMS*SCORE_WIDTH-1:0] scores,
   output logic                             game_on,
   output logic                             game_paused,
   output logic                             game_over,
   output logic                             second_tick,
   output logic                             winner_valid,
   output logic [$clog2(NUM_TEAMS)-1:0]     winner_idx,
   output logic                             draw
);

   localparam int IDX_W = idx_w(NUM_TEAMS);
   localparam logic [SCORE_WIDTH-1:0] SCORE_MAX = '1;
   localparam logic [TIME_WIDTH-1:0]  TIME_INIT = TIME_WIDTH'(MATCH_SECONDS);

   match_state_t state, state_next;

   logic [NUM_TEAMS-1:0]   score_hist;
   logic [NUM_TEAMS-1:0]   goal;
   logic [SCORE_WIDTH-1:0] score_q    [NUM_TEAMS];
   logic [SCORE_WIDTH-1:0] score_next [NUM_TEAMS];
   logic [SCORE_WIDTH-1:0] top_score;
   logic [IDX_W-1:0]       lead_idx;
   logic                   top_tied;
   logic                   counting;
   logic                   presc_tick;
   logic                   expiry;

   sec_prescaler #(
      .CLK_FREQ_HZ(CLK_FREQ_HZ)
   ) u_prescaler (
      .clk (clk),
      .rst (rst),
      .run (state == PLAYING),
      .tick(presc_tick)
   );

   assign goal     = score_toggle ^ score_hist;
   assign counting = (state == PLAYING) || (state == OVERTIME);
   assign expiry   = presc_tick && (time_left == TIME_WIDTH'(1));

   // Scores as they will be after this edge; the tie decision and the
   // winner are taken from these so a goal in the expiry cycle counts.
   always_comb begin
      score_next = score_q;
      for (int i = 0; i < NUM_TEAMS; i++) begin
         if (counting && goal[i] && (score_q[i] != SCORE_MAX)) begin
            score_next[i] = score_q[i] + SCORE_WIDTH'(1);
         end
      end
   end

   // Find the top score, its team, and whether another team shares it.
   always_comb begin
      top_score = score_next[0];
      lead_idx  = '0;
      top_tied  = 1'b0;
      for (int i = 1; i < NUM_TEAMS; i++) begin
         if (score_next[i] > top_score) begin
            top_score = score_next[i];
            lead_idx  = IDX_W'(i);
            top_tied  = 1'b0;
         end else if (score_next[i] == top_score) begin
            top_tied = 1'b1;
         end
      end
   end

   // Next-state logic; expiry is checked before pause so a pause in the
   // expiry cycle is dropped.
   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (start_req) state_next = PLAYING;
         end
         PLAYING: begin
            if (expiry) begin
`ifdef MATCH_OVERTIME_EN
               state_next = top_tied ? OVERTIME : OVER;
`else
               state_next = OVER;
`endif
            end else if (pause_req) begin
               state_next = PAUSED;
            end
         end
         PAUSED: begin
            if (pause_req) state_next = PLAYING;
         end
`ifdef MATCH_OVERTIME_EN
         OVERTIME: begin
            if (!top_tied) state_next = OVER;
         end
`endif
         OVER: begin
            state_next = OVER;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // State, countdown, scores and result registers. score_hist reloads
   // from the live toggles at reset so no goal is seen on the first cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         time_left    <= TIME_INIT;
         score_hist   <= score_toggle;
         second_tick  <= 1'b0;
         winner_valid <= 1'b0;
         winner_idx   <= '0;
         draw         <= 1'b0;
         for (int i = 0; i < NUM_TEAMS; i++) begin
            score_q[i] <= '0;
         end
      end else begin
         state       <= state_next;
         score_hist  <= score_toggle;
         second_tick <= 1'b0;
         for (int i = 0; i < NUM_TEAMS; i++) begin
            score_q[i] <= score_next[i];
         end
         if (presc_tick && (time_left != '0)) begin
            time_left   <= time_left - TIME_WIDTH'(1);
            second_tick <= 1'b1;
         end
         if ((state != OVER) && (state_next == OVER)) begin
            winner_valid <= !top_tied;
            winner_idx   <= top_tied ? '0 : lead_idx;
            draw         <= top_tied;
         end
      end
   end

   for (genvar g = 0; g < NUM_TEAMS; g++) begin : g_pack
      assign scores[g*SCORE_WIDTH +: SCORE_WIDTH] = score_q[g];
   end

   assign game_on     = counting;
   assign game_paused = (state == PAUSED);
   assign game_over   = (state == OVER);

endmodule
